// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply / restoring divide sequencer producing a HI/LO result pair.
// Latency: WIDTH+2 edges from the accepting edge to the done cycle; divide-by-zero finishes in one.
// Backpressure: stall holds the pipeline while a request is accepted or calculating; start while busy is dropped.
module muldiv_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       multiDiv,
  input  logic             flush,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [1:0]       regWrite,
  output logic [WIDTH-1:0] resultHi,
  output logic [WIDTH-1:0] resultLo,
  output logic             divByZero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  // acc: upper product accumulator / partial remainder, one bit wider for carry and borrow
  logic [WIDTH:0]   acc;
  // mq: multiplier shifting out on mul, dividend shifting out / quotient shifting in on div
  logic [WIDTH-1:0] mq;
  // opnd: multiplicand magnitude on mul, divisor magnitude on div
  logic [WIDTH-1:0] opnd;

  logic             valid_req;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem_sh;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Request decode, operand magnitudes, one iteration of each datapath and the sign fix-up
  always_comb begin
    valid_req  = start & ((multiDiv == 2'b01) | (multiDiv == 2'b10));
    // the most negative value maps to its unsigned magnitude (0x8000 stays 0x8000)
    mag_a      = opA[WIDTH-1] ? (~opA + 1'b1) : opA;
    mag_b      = opB[WIDTH-1] ? (~opB + 1'b1) : opB;
    mul_sum    = mq[0] ? (acc + {1'b0, opnd}) : acc;
    div_rem_sh = {acc[WIDTH-1:0], mq[WIDTH-1]};
    div_diff   = div_rem_sh - {1'b0, opnd};
    prod       = {acc[WIDTH-1:0], mq};
    prod_fix   = (sign_a ^ sign_b) ? (~prod + 1'b1) : prod;
    quo_fix    = (sign_a ^ sign_b) ? (~mq + 1'b1) : mq;
    rem_fix    = sign_a ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  end

  // Pipeline hold: the request cycle and all working states, but released on the done cycle
  always_comb begin
    stall = ((state == IDLE) & valid_req) | (state == CALC) | (state == FIX);
    busy  = (state != IDLE);
  end

  // Sequencer FSM with registered done/regWrite pulse and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      acc       <= '0;
      mq        <= '0;
      opnd      <= '0;
      done      <= 1'b0;
      regWrite  <= 2'b00;
      resultHi  <= '0;
      resultLo  <= '0;
      divByZero <= 1'b0;
    end else begin
      done     <= 1'b0;
      regWrite <= 2'b00;
      if (flush) begin
        // abort wins over everything else; results and divByZero stay as they were
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (valid_req) begin
              is_div    <= (multiDiv == 2'b10);
              sign_a    <= opA[WIDTH-1];
              sign_b    <= opB[WIDTH-1];
              acc       <= '0;
              cnt       <= CNT_W'(WIDTH - 1);
              divByZero <= 1'b0;
              if (multiDiv == 2'b10) begin
                mq   <= mag_a;
                opnd <= mag_b;
              end else begin
                mq   <= mag_b;
                opnd <= mag_a;
              end
              if ((multiDiv == 2'b10) && (opB == '0)) begin
                // divide by zero short-circuits straight to the done cycle
                resultLo  <= '1;
                resultHi  <= opA;
                divByZero <= 1'b1;
                done      <= 1'b1;
                regWrite  <= 2'b11;
                state     <= DONE;
              end else begin
                state <= CALC;
              end
            end
          end
          CALC: begin
            if (is_div) begin
              acc <= div_diff[WIDTH] ? div_rem_sh : div_diff;
              mq  <= {mq[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
              acc <= {1'b0, mul_sum[WIDTH:1]};
              mq  <= {mul_sum[0], mq[WIDTH-1:1]};
            end
            if (cnt == '0) begin
              state <= FIX;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          FIX: begin
            if (is_div) begin
              resultHi <= rem_fix;
              resultLo <= quo_fix;
            end else begin
              resultHi <= prod_fix[2*WIDTH-1:WIDTH];
              resultLo <= prod_fix[WIDTH-1:0];
            end
            done     <= 1'b1;
            regWrite <= 2'b11;
            state    <= DONE;
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO/divByZero and done cycle queued at issue.
// Checks reset state, latency, invalid codes, re-pulsed start, flush and mid-operation reset.
// Every comparison goes through chk; one summary line at the end.
module tb_muldiv_sequencer;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    multiDiv = 2'b00;
  logic          flush = 1'b0;
  logic [W-1:0]  opA = '0;
  logic [W-1:0]  opB = '0;
  logic          stall;
  logic          busy;
  logic          done;
  logic [1:0]    regWrite;
  logic [W-1:0]  resultHi;
  logic [W-1:0]  resultLo;
  logic          divByZero;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .multiDiv(multiDiv), .flush(flush),
    .opA(opA), .opB(opB), .stall(stall), .busy(busy), .done(done),
    .regWrite(regWrite), .resultHi(resultHi), .resultLo(resultLo), .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic         last_dbz = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference arithmetic using the language's own signed operators
  function automatic exp_t model(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint p;
    int     q;
    int     r;
    e.due = 0;
    e.dbz = 1'b0;
    if (md == 2'b01) begin
      p = longint'($signed(a)) * longint'($signed(b));
      e.hi = p[31:16];
      e.lo = p[15:0];
    end else if (b == '0) begin
      e.hi = a;
      e.lo = 16'hFFFF;
      e.dbz = 1'b1;
    end else begin
      q = int'($signed(a)) / int'($signed(b));
      r = int'($signed(a)) % int'($signed(b));
      e.lo = q[15:0];
      e.hi = r[15:0];
    end
    return e;
  endfunction

  // output monitor: every done must match the oldest expectation, on the expected cycle
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resultHi", resultHi, mon_e.hi);
        chk("resultLo", resultLo, mon_e.lo);
        chk("divByZero", divByZero, mon_e.dbz);
        chk("done_cycle", cyc, mon_e.due);
        chk("regWrite", regWrite, 32'd3);
        chk("stall_on_done", stall, 32'd0);
        last_hi  = mon_e.hi;
        last_lo  = mon_e.lo;
        last_dbz = mon_e.dbz;
      end
    end
    if (rst_n && !done && regWrite != 2'b00) chk("regWrite_idle", regWrite, 32'd0);
  end

  // one-cycle start pulse from IDLE; queues the expectation for valid codes
  task automatic issue(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   valid;
    int   lat;
    valid = (md == 2'b01) || (md == 2'b10);
    lat   = (md == 2'b10 && b == '0) ? 0 : W + 1;
    @(negedge clk);
    start = 1'b1; multiDiv = md; opA = a; opB = b;
    if (valid) begin
      e = model(md, a, b);
      e.due = cyc + 1 + lat;
      sb.push_back(e);
    end
    #1 chk("stall_req", stall, valid);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_accept", busy, valid);
    chk("stall_after_accept", stall, valid && lat != 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_regWrite", regWrite, 0);
    chk("rst_hi", resultHi, 0);
    chk("rst_lo", resultLo, 0);
    chk("rst_dbz", divByZero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;

    issue(2'b01, 16'hFFFD, 16'h0005); drain();
    issue(2'b10, 16'hFFF9, 16'h0002); drain();
    issue(2'b10, 16'h1234, 16'h0000); drain();
    issue(2'b10, 16'h8000, 16'hFFFF); drain();
    issue(2'b01, 16'h8000, 16'h8000); drain();

    // invalid op codes: no stall, no state change, no done
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b1; multiDiv = (i == 0) ? 2'b00 : 2'b11; opA = 16'h0011; opB = 16'h0000;
      #1;
      chk("inv_stall", stall, 0);
      @(negedge clk);
      start = 1'b0;
      chk("inv_busy", busy, 0);
    end
    repeat (3) @(negedge clk);
    chk("inv_hi_held", resultHi, last_hi);

    // start re-pulsed mid-CALC with a would-be divide-by-zero: ignored
    issue(2'b01, 16'h0123, 16'hFF00);
    repeat (4) @(negedge clk);
    start = 1'b1; multiDiv = 2'b10; opA = 16'h0005; opB = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    chk("repulse_dbz", divByZero, 0);

    // flush when the counter reads 7: idle next edge, no done, results held
    issue(2'b01, 16'h7FFF, 16'h7FFF);
    void'(sb.pop_back());
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_stall", stall, 0);
    repeat (20) @(negedge clk);
    chk("flush_hi", resultHi, last_hi);
    chk("flush_lo", resultLo, last_lo);
    chk("flush_dbz", divByZero, last_dbz);

    // reset mid-CALC: everything clears, no done afterwards
    issue(2'b10, 16'h4000, 16'h0003);
    void'(sb.pop_back());
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_regWrite", regWrite, 0);
    chk("mrst_hi", resultHi, 0);
    chk("mrst_lo", resultLo, 0);
    chk("mrst_dbz", divByZero, 0);
    rst_n = 1'b1;
    last_hi = '0; last_lo = '0; last_dbz = 1'b0;
    repeat (20) @(negedge clk);

    issue(2'b01, 16'h0007, 16'hFFFE); drain();
    issue(2'b10, 16'h7FFF, 16'h8000); drain();

    for (int i = 0; i < 10; i++) begin
      logic [1:0]   md;
      logic [W-1:0] a;
      logic [W-1:0] b;
      md = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      a  = W'($urandom);
      b  = (i == 7) ? '0 : W'($urandom);
      issue(md, a, b);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
